// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits a burst of num_pulses clock-aligned pulses with
// programmable high and low widths, reporting busy/done/progress to a controller.
module pulse_train_gen #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [CNT_W-1:0] high_cycles,
    input  logic [CNT_W-1:0] low_cycles,
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_sent
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Latched burst configuration (widths already clamped to a minimum of 1)
    logic [CNT_W-1:0] num_q,  num_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] low_q,  low_d;

    // Cycles already spent in the current HIGH/LOW phase
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0] pulses_sent_q, pulses_sent_d;

    logic pulse_out_q, pulse_out_d;
    logic busy_q,      busy_d;
    logic done_q,      done_d;

    // Decode helpers
    logic             accept_c;
    logic             abort_c;
    logic [CNT_W-1:0] phase_next_c;
    logic [CNT_W-1:0] pulses_next_c;
    logic             high_end_c;
    logic             low_end_c;
    logic             last_pulse_c;
    logic [CNT_W-1:0] high_eff_c;
    logic [CNT_W-1:0] low_eff_c;

    // Phase-end and acceptance decode shared by the FSM and the datapath
    always_comb begin
        accept_c      = (state_q == S_IDLE) && start;
        abort_c       = (state_q != S_IDLE) && abort;
        phase_next_c  = phase_cnt_q + CNT_W'(1);
        pulses_next_c = pulses_sent_q + CNT_W'(1);
        high_end_c    = (phase_next_c == high_q);
        low_end_c     = (phase_next_c == low_q);
        last_pulse_c  = (pulses_next_c == num_q);
        high_eff_c    = (high_cycles == '0) ? CNT_W'(1) : high_cycles;
        low_eff_c     = (low_cycles  == '0) ? CNT_W'(1) : low_cycles;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort returns to IDLE from any non-idle state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (num_pulses == '0) ? S_DONE : S_HIGH;
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (high_end_c) begin
                    state_d = last_pulse_c ? S_DONE : S_LOW;
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (low_end_c) begin
                    state_d = S_HIGH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: outputs are registered copies of what the next state implies
    always_comb begin
        pulse_out_d = (state_d == S_HIGH);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // Datapath next values: config latch, phase counter, pulse counter
    always_comb begin
        num_d         = num_q;
        high_d        = high_q;
        low_d         = low_q;
        phase_cnt_d   = phase_cnt_q;
        pulses_sent_d = pulses_sent_q;

        if (accept_c) begin
            num_d         = num_pulses;
            high_d        = high_eff_c;
            low_d         = low_eff_c;
            phase_cnt_d   = '0;
            pulses_sent_d = '0;
        end else if (abort_c) begin
            // Progress count is kept for the controller to read back
            phase_cnt_d = '0;
        end else begin
            case (state_q)
                S_HIGH: begin
                    if (high_end_c) begin
                        phase_cnt_d   = '0;
                        pulses_sent_d = pulses_next_c;
                    end else begin
                        phase_cnt_d = phase_next_c;
                    end
                end
                S_LOW: begin
                    phase_cnt_d = low_end_c ? '0 : phase_next_c;
                end
                default: begin
                    phase_cnt_d = '0;
                end
            endcase
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            num_q         <= '0;
            high_q        <= '0;
            low_q         <= '0;
            phase_cnt_q   <= '0;
            pulses_sent_q <= '0;
            pulse_out_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            num_q         <= num_d;
            high_q        <= high_d;
            low_q         <= low_d;
            phase_cnt_q   <= phase_cnt_d;
            pulses_sent_q <= pulses_sent_d;
            pulse_out_q   <= pulse_out_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign pulse_out   = pulse_out_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pulses_sent = pulses_sent_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: closed-form burst timing model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pulse_train_gen;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_pulses;
    logic [CNT_W-1:0] high_cycles;
    logic [CNT_W-1:0] low_cycles;
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_sent;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_train_gen #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .num_pulses  (num_pulses),
        .high_cycles (high_cycles),
        .low_cycles  (low_cycles),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_sent (pulses_sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Edge count, accept edge, latched burst (N, H, L) and held count after abort/reset
    int e = 0;
    int a = 0;
    bit act = 1'b0;
    int mn = 0, mh = 1, ml = 1;
    int ps_hold = 0;

    function automatic int burst_end(input int n, input int h, input int l);
        return (n == 0) ? 0 : n * h + (n - 1) * l;
    endfunction

    // Expected outputs in the d-th cycle after the accept edge (d >= 1)
    task automatic model_at(input int d, output logic p, output logic b,
                            output logic dn, output int ps);
        int ee, per, k, r;
        ee  = burst_end(mn, mh, ml);
        per = mh + ml;
        if (d <= ee) begin
            k  = (d - 1) / per;
            r  = (d - 1) % per;
            p  = (r < mh);
            ps = k + ((r >= mh) ? 1 : 0);
            b  = 1'b1;
            dn = 1'b0;
        end else if (d == ee + 1) begin
            p = 1'b0; b = 1'b1; dn = 1'b1; ps = mn;
        end else begin
            p = 1'b0; b = 1'b0; dn = 1'b0; ps = mn;
        end
    endtask

    logic m_p, m_b, m_dn;
    int   m_ps;

    // Model advance on each edge from the sampled inputs
    always @(posedge clk) begin
        int d_prev;
        bit idle;
        d_prev = e - a + 1;
        idle   = !act || (d_prev >= burst_end(mn, mh, ml) + 2);
        if (!rst) begin
            act     = 1'b0;
            ps_hold = 0;
        end else if (idle) begin
            if (start) begin
                act = 1'b1;
                a   = e + 1;
                mn  = int'(num_pulses);
                mh  = (high_cycles == 0) ? 1 : int'(high_cycles);
                ml  = (low_cycles  == 0) ? 1 : int'(low_cycles);
            end
        end else if (abort) begin
            model_at(d_prev, m_p, m_b, m_dn, m_ps);
            ps_hold = m_ps;
            act     = 1'b0;
        end
        e = e + 1;
    end

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        if (e >= 1) begin
            if (act) begin
                model_at(e - a + 1, m_p, m_b, m_dn, m_ps);
            end else begin
                m_p = 1'b0; m_b = 1'b0; m_dn = 1'b0; m_ps = ps_hold;
            end
            chk("model_pulse_out", 32'(pulse_out), 32'(m_p));
            chk("model_busy", 32'(busy), 32'(m_b));
            chk("model_done", 32'(done), 32'(m_dn));
            chk("model_pulses_sent", 32'(pulses_sent), 32'(m_ps));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Presents start for one edge; returns in the first cycle of the burst
    task automatic start_burst(input int n, input int h, input int l);
        num_pulses  = CNT_W'(n);
        high_cycles = CNT_W'(h);
        low_cycles  = CNT_W'(l);
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    int pat1 [10] = '{1, 1, 0, 1, 1, 0, 1, 1, 0, 0};

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        num_pulses = '0; high_cycles = '0; low_cycles = '0;
        tick();
        tick();
        chk("reset_pulse_out", 32'(pulse_out), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_pulses_sent", 32'(pulses_sent), 0);
        rst = 1'b1;
        tick();

        // Single burst N=3, H=2, L=1
        start_burst(3, 2, 1);
        for (int d = 1; d <= 10; d++) begin
            chk("t1_pulse", 32'(pulse_out), 32'(pat1[d-1]));
            chk("t1_done", 32'(done), (d == 9) ? 1 : 0);
            chk("t1_busy", 32'(busy), (d <= 9) ? 1 : 0);
            if (d == 9) chk("t1_sent", 32'(pulses_sent), 3);
            tick();
        end
        wait_cycles(2);

        // num=0: immediate done, no pulse
        start_burst(0, 5, 5);
        chk("t2_done", 32'(done), 1);
        chk("t2_pulse", 32'(pulse_out), 0);
        chk("t2_sent", 32'(pulses_sent), 0);
        tick();
        chk("t2_done_clear", 32'(done), 0);
        wait_cycles(2);

        // num=1 with zero widths treated as 1
        start_burst(1, 0, 0);
        chk("t3_pulse_d1", 32'(pulse_out), 1);
        tick();
        chk("t3_pulse_d2", 32'(pulse_out), 0);
        chk("t3_done_d2", 32'(done), 1);
        chk("t3_sent", 32'(pulses_sent), 1);
        wait_cycles(3);

        // Full-scale burst: 255 pulses, no counter wrap
        start_burst(255, 1, 1);
        for (int d = 1; d <= 511; d++) begin
            if (d == 509) chk("t4_done_early", 32'(done), 0);
            if (d == 510) begin
                chk("t4_done", 32'(done), 1);
                chk("t4_sent", 32'(pulses_sent), 255);
            end
            tick();
        end
        wait_cycles(2);

        // Start held throughout: ignored until IDLE, re-accepted after done
        num_pulses = 8'd2; high_cycles = 8'd3; low_cycles = 8'd2; start = 1'b1;
        tick();
        for (int d = 1; d <= 11; d++) begin
            if (d == 9)  chk("t5_done", 32'(done), 1);
            if (d == 10) chk("t5_idle_busy", 32'(busy), 0);
            if (d == 11) chk("t5_restart_pulse", 32'(pulse_out), 1);
            tick();
        end
        start = 1'b0;
        wait_cycles(12);

        // Config inputs changed after accept have no effect
        start_burst(4, 2, 2);
        tick();
        num_pulses = 8'd1; high_cycles = 8'd5; low_cycles = 8'd7;
        for (int d = 2; d <= 16; d++) begin
            if (d == 13 || d == 14) chk("t6_pulse4", 32'(pulse_out), 1);
            if (d == 15) begin
                chk("t6_done", 32'(done), 1);
                chk("t6_sent", 32'(pulses_sent), 4);
            end
            tick();
        end
        wait_cycles(2);

        // Abort during the third high phase
        start_burst(5, 2, 2);
        wait_cycles(8);
        chk("t7_pulse_before_abort", 32'(pulse_out), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t7_pulse", 32'(pulse_out), 0);
        chk("t7_busy", 32'(busy), 0);
        chk("t7_sent", 32'(pulses_sent), 2);
        for (int i = 0; i < 20; i++) begin
            chk("t7_no_done", 32'(done), 0);
            tick();
        end
        start_burst(2, 1, 1);
        wait_cycles(6);
        chk("t7_fresh_sent", 32'(pulses_sent), 2);

        // Reset during a LOW phase, then abort in IDLE and start+abort together
        start_burst(3, 2, 3);
        wait_cycles(2);
        chk("t8_in_low", 32'(pulse_out), 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("t8_rst_busy", 32'(busy), 0);
        chk("t8_rst_sent", 32'(pulses_sent), 0);
        abort = 1'b1;
        wait_cycles(2);
        chk("t8_idle_abort_busy", 32'(busy), 0);
        start_burst(2, 2, 1);
        abort = 1'b0;
        chk("t8_start_wins", 32'(pulse_out), 1);
        wait_cycles(8);
        chk("t8_sent", 32'(pulses_sent), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
